// File: rtl/generic_cntr_hw_regs.sv
// Bank of 32-bit event counters on the register ring; reads/writes hit on TAG + word index.
// Latency 1 cycle for every ring word; no backpressure, a new request is accepted each cycle.
// Optional GENERIC_CNTR_RESET_ON_READ_EN: a read hit clears the counter while keeping that cycle's update.

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module generic_cntr_hw_regs #(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int TAG               = 0,
  parameter int REG_ADDR_WIDTH    = 2,
  parameter int NUM_REGS_USED     = 4,
  parameter int INPUT_WIDTH       = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,

  input  logic                                 reg_req_in,
  input  logic                                 reg_ack_in,
  input  logic                                 reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]       reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]      reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]         reg_src_in,

  output logic                                 reg_req_out,
  output logic                                 reg_ack_out,
  output logic                                 reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]       reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]      reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]         reg_src_out,

  input  logic [NUM_REGS_USED*INPUT_WIDTH-1:0] counter_updates,
  input  logic [NUM_REGS_USED-1:0]             counter_decrement
);

  localparam int AW    = `UDP_REG_ADDR_WIDTH;
  localparam int DW    = `CPCI_NF2_DATA_WIDTH;
  localparam int TAG_W = AW - REG_ADDR_WIDTH;

  localparam logic [TAG_W-1:0]        TAG_V = TAG_W'(TAG);
  localparam logic [REG_ADDR_WIDTH:0] NUM_V = (REG_ADDR_WIDTH + 1)'(NUM_REGS_USED);

  logic [TAG_W-1:0]          addr_tag;
  logic [REG_ADDR_WIDTH-1:0] addr_idx;
  logic                      tag_match;
  logic                      idx_valid;
  logic                      hit;
  logic                      rd_hit;
  logic                      wr_hit;
  logic [DW-1:0]             rd_dat;
  logic [DW-1:0]             cntr [NUM_REGS_USED];

  assign addr_tag  = reg_addr_in[AW-1:REG_ADDR_WIDTH];
  assign addr_idx  = reg_addr_in[REG_ADDR_WIDTH-1:0];
  assign tag_match = (addr_tag == TAG_V);
  assign idx_valid = ({1'b0, addr_idx} < NUM_V);

  // A word already acked upstream belongs to another block and is never decoded here.
  assign hit    = reg_req_in && !reg_ack_in && tag_match && idx_valid;
  assign rd_hit = hit && reg_rd_wr_L_in;
  assign wr_hit = hit && !reg_rd_wr_L_in;

  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < NUM_REGS_USED; i++) begin
      if (addr_idx == REG_ADDR_WIDTH'(i)) rd_dat = cntr[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS_USED; g++) begin : g_cntr
    logic [DW-1:0] delta;
    logic [DW-1:0] base;
    logic [DW-1:0] nxt;
    logic [DW-1:0] cnt_q;
    logic          sel;

    assign delta   = DW'(counter_updates[INPUT_WIDTH*g +: INPUT_WIDTH]);
    assign sel     = (addr_idx == REG_ADDR_WIDTH'(g));
    assign cntr[g] = cnt_q;

    always_comb begin
      base = cnt_q;
`ifdef GENERIC_CNTR_RESET_ON_READ_EN
      // The read returns cnt_q; starting from zero keeps this cycle's events.
      if (rd_hit && sel) base = '0;
`endif
      nxt = counter_decrement[g] ? (base - delta) : (base + delta);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (wr_hit && sel) begin
        cnt_q <= reg_data_in;
      end else begin
        cnt_q <= nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
    end else begin
      reg_req_out     <= reg_req_in;
      reg_ack_out     <= reg_ack_in | hit;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_data_out    <= rd_hit ? rd_dat : reg_data_in;
      reg_src_out     <= reg_src_in;
    end
  end

endmodule

// File: tb/tb_generic_cntr_hw_regs.sv
// Scoreboard bench for generic_cntr_hw_regs: a 4-counter instance and a 3-counter instance share the ring.
// Expected ring words are pushed when driven and popped one cycle later.

module tb_generic_cntr_hw_regs;

  localparam int N  = 4;
  localparam int IW = 2;
`ifdef GENERIC_CNTR_RESET_ON_READ_EN
  localparam bit ROR = 1'b1;
`else
  localparam bit ROR = 1'b0;
`endif

  typedef struct packed {
    logic        req;
    logic        ack;
    logic        rw;
    logic [22:0] addr;
    logic [31:0] data;
    logic [1:0]  src;
  } ring_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [22:0] reg_addr_in;
  logic [31:0] reg_data_in;
  logic [1:0]  reg_src_in;
  logic [N*IW-1:0] counter_updates;
  logic [N-1:0]    counter_decrement;

  logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [22:0] reg_addr_out;
  logic [31:0] reg_data_out;
  logic [1:0]  reg_src_out;

  logic        s_req_out, s_ack_out, s_rd_wr_L_out;
  logic [22:0] s_addr_out;
  logic [31:0] s_data_out;
  logic [1:0]  s_src_out;
  logic [3*IW-1:0] s_counter_updates   = '0;
  logic [2:0]      s_counter_decrement = '0;

  always #5 clk = ~clk;

  generic_cntr_hw_regs u_dut (
    .clk               (clk),
    .reset             (reset),
    .reg_req_in        (reg_req_in),
    .reg_ack_in        (reg_ack_in),
    .reg_rd_wr_L_in    (reg_rd_wr_L_in),
    .reg_addr_in       (reg_addr_in),
    .reg_data_in       (reg_data_in),
    .reg_src_in        (reg_src_in),
    .reg_req_out       (reg_req_out),
    .reg_ack_out       (reg_ack_out),
    .reg_rd_wr_L_out   (reg_rd_wr_L_out),
    .reg_addr_out      (reg_addr_out),
    .reg_data_out      (reg_data_out),
    .reg_src_out       (reg_src_out),
    .counter_updates   (counter_updates),
    .counter_decrement (counter_decrement)
  );

  generic_cntr_hw_regs #(.NUM_REGS_USED(3)) u_dut3 (
    .clk               (clk),
    .reset             (reset),
    .reg_req_in        (reg_req_in),
    .reg_ack_in        (reg_ack_in),
    .reg_rd_wr_L_in    (reg_rd_wr_L_in),
    .reg_addr_in       (reg_addr_in),
    .reg_data_in       (reg_data_in),
    .reg_src_in        (reg_src_in),
    .reg_req_out       (s_req_out),
    .reg_ack_out       (s_ack_out),
    .reg_rd_wr_L_out   (s_rd_wr_L_out),
    .reg_addr_out      (s_addr_out),
    .reg_data_out      (s_data_out),
    .reg_src_out       (s_src_out),
    .counter_updates   (s_counter_updates),
    .counter_decrement (s_counter_decrement)
  );

  int    n_chk  = 0;
  int    n_pass = 0;
  ring_t exp_q  [$];
  ring_t exps_q [$];
  logic [31:0] m_cnt [4];
  logic [31:0] s_cnt [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Drive one ring word, predict both instances' outputs, then compare one cycle later.
  task automatic step(input string tag, input logic rst, input logic req, input logic ack,
                      input logic rw, input logic [22:0] addr, input logic [31:0] data,
                      input logic [7:0] upd, input logic [3:0] dec);
    ring_t e, es, o, os;
    logic hit, hit_s;
    int idx;
    logic [31:0] delta, base;
    reset = rst; reg_req_in = req; reg_ack_in = ack; reg_rd_wr_L_in = rw;
    reg_addr_in = addr; reg_data_in = data; reg_src_in = 2'($urandom);
    counter_updates = upd; counter_decrement = dec;
    idx   = int'(addr[1:0]);
    hit   = req && !ack && (addr[22:2] == 21'd0) && (idx < 4);
    hit_s = req && !ack && (addr[22:2] == 21'd0) && (idx < 3);
    if (rst) begin
      e = '0; es = '0;
    end else begin
      e  = {req, ack | hit,   rw, addr, (hit && rw)   ? m_cnt[idx] : data, reg_src_in};
      es = {req, ack | hit_s, rw, addr, (hit_s && rw) ? s_cnt[idx] : data, reg_src_in};
    end
    for (int i = 0; i < 4; i++) begin
      delta = 32'(upd[2*i +: 2]);
      if (rst) m_cnt[i] = '0;
      else if (hit && !rw && idx == i) m_cnt[i] = data;
      else begin
        base = (ROR && hit && rw && idx == i) ? 32'd0 : m_cnt[i];
        m_cnt[i] = dec[i] ? base - delta : base + delta;
      end
      if (i < 3) begin
        if (rst) s_cnt[i] = '0;
        else if (hit_s && !rw && idx == i) s_cnt[i] = data;
        else if (ROR && hit_s && rw && idx == i) s_cnt[i] = '0;
      end
    end
    exp_q.push_back(e);
    exps_q.push_back(es);
    @(posedge clk);
    #1;
    o  = {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out};
    os = {s_req_out, s_ack_out, s_rd_wr_L_out, s_addr_out, s_data_out, s_src_out};
    chk(tag, 64'(o), 64'(exp_q.pop_front()));
    chk({tag, "_n3"}, 64'(os), 64'(exps_q.pop_front()));
  endtask

  task automatic idle(input logic [7:0] upd, input logic [3:0] dec);
    step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 23'd0, 32'd0, upd, dec);
  endtask

  task automatic rd(input string tag, input logic [22:0] addr, input logic [7:0] upd, input logic [3:0] dec);
    step(tag, 1'b0, 1'b1, 1'b0, 1'b1, addr, 32'hDEAD_BEEF, upd, dec);
  endtask

  task automatic wr(input string tag, input logic [22:0] addr, input logic [31:0] data);
    step(tag, 1'b0, 1'b1, 1'b0, 1'b0, addr, data, 8'd0, 4'd0);
  endtask

  initial begin
    foreach (m_cnt[i]) begin m_cnt[i] = '0; s_cnt[i] = '0; end

    // Reset with a busy ring: all outputs must clear.
    step("rst0", 1'b1, 1'b1, 1'b0, 1'b1, 23'd1, 32'h1234_5678, 8'hFF, 4'h0);
    step("rst1", 1'b1, 1'b1, 1'b1, 1'b0, 23'h7F_FFFF, 32'hFFFF_FFFF, 8'hFF, 4'hF);
    chk("rst_ack", 64'(reg_ack_out), 64'(0));
    chk("rst_dat", 64'(reg_data_out), 64'(0));

    // Field 0 = 2 for five cycles.
    repeat (5) idle(8'h02, 4'h0);
    rd("rd_c0", 23'd0, 8'h00, 4'h0);
    chk("c0_ten", 64'(reg_data_out), 64'(32'd10));
    chk("c0_ack", 64'(reg_ack_out), 64'(1));

    // Wrap through 2^32.
    wr("wr_c1", 23'd1, 32'hFFFF_FFFF);
    idle(8'h0C, 4'h0);
    rd("rd_c1", 23'd1, 8'h00, 4'h0);
    chk("c1_wrap", 64'(reg_data_out), 64'(32'h0000_0002));

    // Decrement on the read cycle, then a plain read.
    wr("wr_c2", 23'd2, 32'd7);
    rd("rd_c2a", 23'd2, 8'h10, 4'h4);
    chk("c2_pre", 64'(reg_data_out), 64'(32'd7));
    rd("rd_c2b", 23'd2, 8'h00, 4'h0);
    chk("c2_post", 64'(reg_data_out), ROR ? 64'(32'hFFFF_FFFF) : 64'(32'd6));

    // Pass-through cases: already acked, wrong tag, index past the last counter.
    step("acked", 1'b0, 1'b1, 1'b1, 1'b1, 23'd0, 32'h0000_1234, 8'h00, 4'h0);
    chk("acked_dat", 64'(reg_data_out), 64'(32'h0000_1234));
    step("wtag", 1'b0, 1'b1, 1'b0, 1'b1, 23'h14, 32'h0000_ABCD, 8'h00, 4'h0);
    chk("wtag_ack", 64'(reg_ack_out), 64'(0));
    chk("wtag_dat", 64'(reg_data_out), 64'(32'h0000_ABCD));
    step("oor", 1'b0, 1'b1, 1'b0, 1'b1, 23'd3, 32'h0000_5555, 8'h00, 4'h0);
    chk("oor_ack", 64'(s_ack_out), 64'(0));
    chk("oor_dat", 64'(s_data_out), 64'(32'h0000_5555));
    step("wr_oor", 1'b0, 1'b1, 1'b0, 1'b0, 23'd3, 32'h0000_0099, 8'h00, 4'h0);

    // Back-to-back reads with every field counting.
    for (int a = 0; a < 4; a++) begin
      rd($sformatf("b2b%0d", a), 23'(a), 8'h55, 4'h0);
      chk($sformatf("b2b%0d_ack", a), 64'(reg_ack_out), 64'(1));
    end

    // Reset during a read hit drops the request and clears counters.
    step("rst_hit", 1'b1, 1'b1, 1'b0, 1'b1, 23'd0, 32'd0, 8'hFF, 4'h0);
    chk("rst_hit_ack", 64'(reg_ack_out), 64'(0));
    chk("rst_hit_req", 64'(reg_req_out), 64'(0));
    for (int a = 0; a < 4; a++) begin
      rd($sformatf("post_rst%0d", a), 23'(a), 8'h00, 4'h0);
      chk($sformatf("post_rst%0d_dat", a), 64'(reg_data_out), 64'(0));
    end

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      logic [22:0] ad;
      ad = 23'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) ad[22:2] = 21'($urandom_range(1, 3));
      step("rnd", ($urandom_range(0, 40) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 7) == 0), 1'($urandom), ad,
           ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom,
           8'($urandom), 4'($urandom));
    end

    chk("q_empty", 64'(exp_q.size() + exps_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
